// File: rtl/fast_arc_detector_if.sv
// Sample/result bundle for the FAST segment-test stage.
// master drives samples and observes results; slave is the detector side.
interface fast_arc_detector_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic             i_valid;
  logic             i_sof;
  logic [N-1:0]     i_bright;
  logic [N-1:0]     i_dark;
  logic [RW-1:0]    i_arc_len;
  logic             o_valid;
  logic             o_corner;
  logic             o_polarity;
  logic [RW-1:0]    o_run_len;
  logic [IW-1:0]    o_run_start;
  logic [CNT_W-1:0] o_frame_count;

  modport master (
    output i_valid, i_sof, i_bright, i_dark, i_arc_len,
    input  o_valid, o_corner, o_polarity, o_run_len, o_run_start, o_frame_count
  );

  modport slave (
    input  i_valid, i_sof, i_bright, i_dark, i_arc_len,
    output o_valid, o_corner, o_polarity, o_run_len, o_run_start, o_frame_count
  );
endinterface

// File: rtl/fast_arc_detector.sv
// FAST segment test: longest circular bright/dark run on the Bresenham ring,
// corner decision against a per-sample arc length, and a per-frame corner count.
module fast_arc_detector #(
  parameter int N       = 16,
  parameter int ARC_DEF = 9,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fast_arc_detector_if.slave bus
);
  localparam int RW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [RW-1:0] len;
    logic [IW-1:0] start;
  } run_t;

  // A run starts where the bit is set and its circular predecessor is clear;
  // scanning starts upward keeps the lowest start on ties.
  function automatic run_t longest_run(input logic [N-1:0] v);
    run_t          best;
    logic [RW-1:0] cnt;
    logic          open;
    logic [IW-1:0] idx;
    logic [IW-1:0] prev;
    best = '0;
    if (&v) begin
      best.len = RW'(N);
    end else begin
      for (int unsigned s = 0; s < N; s++) begin
        prev = IW'((s + N - 1) % N);
        idx  = IW'(s);
        if (v[idx] && !v[prev]) begin
          cnt  = '0;
          open = 1'b1;
          for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((s + k) % N);
            if (open && v[idx]) cnt = cnt + RW'(1);
            else                open = 1'b0;
          end
          if (cnt > best.len) begin
            best.len   = cnt;
            best.start = IW'(s);
          end
        end
      end
    end
    return best;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sof_q, s1_sof_d;
  logic [N-1:0]     s1_bright_q, s1_bright_d;
  logic [N-1:0]     s1_dark_q, s1_dark_d;
  logic [RW-1:0]    s1_len_q, s1_len_d;

  always_comb begin
    s1_valid_d  = bus.i_valid;
    s1_sof_d    = bus.i_valid & bus.i_sof;
    s1_bright_d = bus.i_bright;
    s1_dark_d   = bus.i_dark;
    s1_len_d    = (bus.i_arc_len == '0) ? RW'(ARC_DEF) : bus.i_arc_len;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_bright_q <= '0;
      s1_dark_q   <= '0;
      s1_len_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_bright_q <= s1_bright_d;
      s1_dark_q   <= s1_dark_d;
      s1_len_q    <= s1_len_d;
    end
  end

  run_t             run_b, run_d;
  logic             corner_b, corner_d;
  logic             o_valid_q, o_valid_d;
  logic             o_corner_q, o_corner_d;
  logic             o_pol_q, o_pol_d;
  logic [RW-1:0]    o_len_q, o_len_d;
  logic [IW-1:0]    o_start_q, o_start_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    run_b      = longest_run(s1_bright_q);
    run_d      = longest_run(s1_dark_q);
    corner_b   = (run_b.len >= s1_len_q);
    corner_d   = (run_d.len >= s1_len_q);
    o_valid_d  = s1_valid_q;
    o_corner_d = 1'b0;
    o_pol_d    = 1'b0;
    o_len_d    = '0;
    o_start_d  = '0;
    fcnt_d     = fcnt_q;
    if (s1_valid_q) begin
      o_corner_d = corner_b | corner_d;
      // Dark wins only when it alone qualifies or is strictly longer.
      o_pol_d    = corner_d & (~corner_b | (run_d.len > run_b.len));
      o_len_d    = o_pol_d ? run_d.len   : run_b.len;
      o_start_d  = o_pol_d ? run_d.start : run_b.start;
      if (s1_sof_q)                      fcnt_d = CNT_W'(o_corner_d);
      else if (o_corner_d && fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_q  <= 1'b0;
      o_corner_q <= 1'b0;
      o_pol_q    <= 1'b0;
      o_len_q    <= '0;
      o_start_q  <= '0;
      fcnt_q     <= '0;
    end else begin
      o_valid_q  <= o_valid_d;
      o_corner_q <= o_corner_d;
      o_pol_q    <= o_pol_d;
      o_len_q    <= o_len_d;
      o_start_q  <= o_start_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign bus.o_valid       = o_valid_q;
  assign bus.o_corner      = o_corner_q;
  assign bus.o_polarity    = o_pol_q;
  assign bus.o_run_len     = o_len_q;
  assign bus.o_run_start   = o_start_q;
  assign bus.o_frame_count = fcnt_q;
endmodule

// File: tb/tb_fast_arc_detector.sv
// Bench for fast_arc_detector: directed literal cases plus a randomized stream
// compared every cycle against a behavioural model of the segment test.
module tb_fast_arc_detector;
  localparam int N     = 16;
  localparam int CNT_W = 4;
  localparam int RW    = 5;
  localparam int IW    = 4;
  localparam int FMAX  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fast_arc_detector_if #(.N(N), .CNT_W(CNT_W)) bus ();

  fast_arc_detector #(.N(N), .ARC_DEF(9), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    bit v;
    bit sof;
    bit corner;
    bit pol;
    int len;
    int start;
  } exp_t;

  typedef struct {
    bit v;
    bit corner;
    bit pol;
    int len;
    int start;
    int fc;
  } dir_t;

  int    tests = 0;
  int    fails = 0;
  exp_t  p1, pout;
  int    fc;
  dir_t  dir_exp;
  string dir_name;
  int    dir_req = 0;
  int    dir_seen = 0;

  // Longest run = max over every start of the count of consecutive ones;
  // the first start reaching the max is the lowest-start winner.
  function automatic void ref_run(input logic [15:0] v, output int len, output int start);
    len = 0;
    start = 0;
    for (int i = 0; i < N; i++) begin
      int c = 0;
      while (c < N && v[(i + c) % N]) c++;
      if (c > len) begin
        len = c;
        start = i;
      end
    end
  endfunction

  function automatic exp_t ref_eval(input logic [15:0] b, input logic [15:0] d,
                                    input int arc, input bit sof);
    exp_t e;
    int lb, sb, ld, sd, eff;
    bit cb, cd;
    ref_run(b, lb, sb);
    ref_run(d, ld, sd);
    eff = (arc == 0) ? 9 : arc;
    cb = (lb >= eff);
    cd = (ld >= eff);
    e.v = 1'b1;
    e.sof = sof;
    e.corner = cb || cd;
    if (cd && (!cb || ld > lb)) begin
      e.pol = 1'b1; e.len = ld; e.start = sd;
    end else begin
      e.pol = 1'b0; e.len = lb; e.start = sb;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 = '{default: 0};
      pout = '{default: 0};
      fc = 0;
    end else begin
      pout = p1;
      if (pout.v) begin
        if (pout.sof) fc = pout.corner ? 1 : 0;
        else if (pout.corner && fc < FMAX) fc++;
      end
      if (bus.i_valid) p1 = ref_eval(bus.i_bright, bus.i_dark, int'(bus.i_arc_len), bus.i_sof);
      else             p1 = '{default: 0};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (bus.o_valid !== pout.v || bus.o_corner !== pout.corner || bus.o_polarity !== pout.pol ||
          bus.o_run_len !== RW'(pout.len) || bus.o_run_start !== IW'(pout.start) ||
          bus.o_frame_count !== CNT_W'(fc)) begin
        fails++;
        $display("FAIL stream t=%0t: got v=%0b c=%0b p=%0b len=%0d st=%0d fc=%0d, expected v=%0b c=%0b p=%0b len=%0d st=%0d fc=%0d",
                 $time, bus.o_valid, bus.o_corner, bus.o_polarity, bus.o_run_len, bus.o_run_start,
                 bus.o_frame_count, pout.v, pout.corner, pout.pol, pout.len, pout.start, fc);
      end
    end
    if (dir_req != dir_seen) begin
      dir_seen = dir_req;
      tests++;
      if (bus.o_valid !== dir_exp.v || bus.o_corner !== dir_exp.corner ||
          bus.o_polarity !== dir_exp.pol || bus.o_run_len !== RW'(dir_exp.len) ||
          bus.o_run_start !== IW'(dir_exp.start) || bus.o_frame_count !== CNT_W'(dir_exp.fc)) begin
        fails++;
        $display("FAIL %s: got v=%0b c=%0b p=%0b len=%0d st=%0d fc=%0d, expected v=%0b c=%0b p=%0b len=%0d st=%0d fc=%0d",
                 dir_name, bus.o_valid, bus.o_corner, bus.o_polarity, bus.o_run_len,
                 bus.o_run_start, bus.o_frame_count, dir_exp.v, dir_exp.corner, dir_exp.pol,
                 dir_exp.len, dir_exp.start, dir_exp.fc);
      end
    end
  end

  task automatic post(input string name, input bit v, input bit c, input bit p,
                      input int len, input int st, input int f);
    dir_name = name;
    dir_exp = '{v: v, corner: c, pol: p, len: len, start: st, fc: f};
    dir_req++;
  endtask

  task automatic drive(input logic [15:0] b, input logic [15:0] d, input int arc, input bit sof);
    bus.i_valid = 1'b1;
    bus.i_sof = sof;
    bus.i_bright = b;
    bus.i_dark = d;
    bus.i_arc_len = RW'(arc);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
  endtask

  task automatic send(input logic [15:0] b, input logic [15:0] d, input int arc, input bit sof);
    drive(b, d, arc, sof);
    idle();
  endtask

  task automatic expect_out(input string name, input bit v, input bit c, input bit p,
                            input int len, input int st, input int f);
    @(posedge clk);
    #1;
    post(name, v, c, p, len, st, f);
  endtask

  function automatic logic [15:0] gen_vec();
    logic [31:0] a;
    int l, r;
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
      default: begin
        l = $urandom_range(0, 16);
        r = $urandom_range(0, 15);
        a = 32'h0000FFFF >> (16 - l);
        a = (a << r) | (a >> (16 - r));
        return a[15:0];
      end
    endcase
  endfunction

  initial begin
    logic [9:0] pat;
    bus.i_valid = 1'b0;
    bus.i_sof = 1'b0;
    bus.i_bright = '0;
    bus.i_dark = '0;
    bus.i_arc_len = '0;
    post("reset_state", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(16'h01FF, 16'h0000, 0, 1'b1);  expect_out("default_arc", 1, 1, 0, 9, 0, 1);
    send(16'hC07F, 16'h0000, 9, 1'b0);  expect_out("wrap_run", 1, 1, 0, 9, 14, 2);
    send(16'h00FF, 16'hFF00, 8, 1'b0);  expect_out("tie_bright", 1, 1, 0, 8, 0, 3);
    send(16'h00FF, 16'hFF00, 9, 1'b0);  expect_out("no_corner", 1, 0, 0, 8, 0, 3);
    send(16'hFFFF, 16'h0000, 0, 1'b0);  expect_out("all_set", 1, 1, 0, 16, 0, 4);
    send(16'hFFFF, 16'h0000, 17, 1'b0); expect_out("arc_over_n", 1, 0, 0, 16, 0, 4);
    send(16'h0000, 16'h5555, 1, 1'b0);  expect_out("alt_dark", 1, 1, 1, 1, 0, 5);
    send(16'h000F, 16'h00FF, 4, 1'b0);  expect_out("dark_longer", 1, 1, 1, 8, 0, 6);
    send(16'hFFFF, 16'hFFFF, 0, 1'b0);  expect_out("both_flags", 1, 1, 0, 16, 0, 7);

    pat = 10'b1011001101;
    for (int i = 0; i < 10; i++)
      drive(pat[i] ? 16'hFFFF : 16'h0001, 16'h0000, 0, i == 0);
    idle();
    expect_out("frame_count6", 1, 1, 0, 16, 0, 6);
    repeat (3) @(posedge clk);
    #1 post("bubble_hold", 0, 0, 0, 0, 0, 6);
    send(16'h0001, 16'h0000, 0, 1'b1);  expect_out("sof_clear", 1, 0, 0, 1, 0, 0);

    for (int i = 0; i < 20; i++) drive(16'hFFFF, 16'h0000, 0, i == 0);
    idle();
    expect_out("saturate", 1, 1, 0, 16, 0, FMAX);

    for (int i = 0; i < 3; i++) drive(16'hFFFF, 16'h0000, 0, 1'b0);
    rst = 1'b1;
    post("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    send(16'h0000, 16'h03FF, 0, 1'b0);
    post("inflight_lost", 0, 0, 0, 0, 0, 0);
    expect_out("post_reset", 1, 1, 1, 10, 0, 1);

    for (int i = 0; i < 600; i++) begin
      bus.i_valid = ($urandom_range(0, 9) < 8);
      bus.i_sof = ($urandom_range(0, 19) == 0);
      bus.i_bright = gen_vec();
      bus.i_dark = gen_vec();
      bus.i_arc_len = RW'($urandom_range(0, 17));
      @(posedge clk);
      #1;
    end
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
